// File: rtl/picoblaze_rtc_port_bank.sv
// picoblaze_rtc_port_bank
//   I/O port bank sitting between a PicoBlaze and the RTC transfer controller.
//   - NUM_FIELDS shadow write registers, committed atomically to wr_fields.
//   - NUM_FIELDS snapshot registers capturing rd_fields for coherent reads.
//   - Field-select register decoded to a one-hot field_en.
//   - Request/acknowledge transfer FSM with sticky done/err status bits.
//
// Ports
//   clk, reset          system clock, synchronous active-high reset
//   write_strobe        PicoBlaze OUTPUT strobe (one cycle)
//   read_strobe         PicoBlaze INPUT strobe (one cycle)
//   port_id, out_port   PicoBlaze address / write data
//   in_port             registered read data (1 cycle after port_id)
//   wr_fields           committed field values, field i at [i*DATA_W +: DATA_W]
//   commit_pulse        one-cycle pulse coincident with a wr_fields update
//   field_en            one-hot decode of the select register (0 if out of range)
//   rd_fields           live RTC field values
//   xfer_req, xfer_ack  transfer handshake: xfer_req is held high from the
//                       cycle after START until the edge that samples the
//                       one-cycle xfer_ack; an ack while idle is ignored.
module picoblaze_rtc_port_bank #(
    parameter int         NUM_FIELDS = 9,
    parameter int         DATA_W     = 8,
    parameter logic [7:0] SEL_PORT   = 8'h01,
    parameter logic [7:0] WR_BASE    = 8'h02,
    parameter logic [7:0] CMD_PORT   = 8'h0B,
    parameter logic [7:0] STAT_PORT  = 8'h0C,
    parameter logic [7:0] RD_BASE    = 8'h0D
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         write_strobe,
    input  logic                         read_strobe,
    input  logic [7:0]                   port_id,
    input  logic [7:0]                   out_port,
    output logic [7:0]                   in_port,
    output logic [NUM_FIELDS*DATA_W-1:0] wr_fields,
    output logic                         commit_pulse,
    output logic [NUM_FIELDS-1:0]        field_en,
    input  logic [NUM_FIELDS*DATA_W-1:0] rd_fields,
    output logic                         xfer_req,
    input  logic                         xfer_ack
);

    typedef enum logic {ST_IDLE, ST_BUSY} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shadow [NUM_FIELDS];
    logic [DATA_W-1:0] snap   [NUM_FIELDS];
    logic [7:0]        sel;
    logic              done, err;
    logic [7:0]        status;
    logic [7:0]        rd_mux;

    logic cmd_wr, cmd_commit, cmd_start, cmd_snap;
    logic done_set, err_set, stat_clr;

    assign cmd_wr     = write_strobe && (port_id == CMD_PORT);
    assign cmd_commit = cmd_wr && (out_port == 8'h01);
    assign cmd_start  = cmd_wr && (out_port == 8'h02);
    assign cmd_snap   = cmd_wr && (out_port == 8'h03);

    assign done_set = (state_q == ST_BUSY) && xfer_ack;
    assign err_set  = (state_q == ST_BUSY) && cmd_start;
    assign stat_clr = read_strobe && (port_id == STAT_PORT);

    assign xfer_req = (state_q == ST_BUSY);
    assign status   = {5'b0, err, done, xfer_req};

    // Shadow registers, commit path and snapshot capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_fields    <= '0;
            commit_pulse <= 1'b0;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                shadow[i] <= '0;
                snap[i]   <= '0;
            end
        end else begin
            commit_pulse <= cmd_commit;
            for (int i = 0; i < NUM_FIELDS; i++) begin
                if (write_strobe && (port_id == WR_BASE + 8'(i)))
                    shadow[i] <= out_port[DATA_W-1:0];
                if (cmd_commit)
                    wr_fields[i*DATA_W +: DATA_W] <= shadow[i];
                if (cmd_snap)
                    snap[i] <= rd_fields[i*DATA_W +: DATA_W];
            end
        end
    end

    // Select register; field_en is decoded from out_port on the same edge so
    // it stays in step with sel.
    always_ff @(posedge clk) begin
        if (reset) begin
            sel      <= 8'h00;
            field_en <= NUM_FIELDS'(1);
        end else if (write_strobe && (port_id == SEL_PORT)) begin
            sel <= out_port;
            for (int i = 0; i < NUM_FIELDS; i++)
                field_en[i] <= (out_port == 8'(i));
        end
    end

    // Transfer FSM.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (cmd_start) state_d = ST_BUSY;
            ST_BUSY: if (xfer_ack)  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Sticky status: a set in the same cycle as clear-on-read takes priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            done <= 1'b0;
            err  <= 1'b0;
        end else begin
            if (done_set)      done <= 1'b1;
            else if (stat_clr) done <= 1'b0;
            if (err_set)       err  <= 1'b1;
            else if (stat_clr) err  <= 1'b0;
        end
    end

    // Read mux, evaluated every cycle regardless of read_strobe.
    always_comb begin
        rd_mux = 8'h00;
        if (port_id == STAT_PORT) rd_mux = status;
        if (port_id == SEL_PORT)  rd_mux = sel;
        for (int i = 0; i < NUM_FIELDS; i++)
            if (port_id == RD_BASE + 8'(i))
                rd_mux[DATA_W-1:0] = snap[i];
    end

    always_ff @(posedge clk) begin
        if (reset) in_port <= 8'h00;
        else       in_port <= rd_mux;
    end

endmodule

// File: tb/tb_picoblaze_rtc_port_bank.sv
module tb_picoblaze_rtc_port_bank;

    localparam int NF = 9;
    localparam int DW = 8;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic             write_strobe, read_strobe;
    logic [7:0]       port_id, out_port, in_port;
    logic [NF*DW-1:0] wr_fields, rd_fields;
    logic             commit_pulse;
    logic [NF-1:0]    field_en;
    logic             xfer_req, xfer_ack;

    picoblaze_rtc_port_bank dut (
        .clk          (clk),
        .reset        (reset),
        .write_strobe (write_strobe),
        .read_strobe  (read_strobe),
        .port_id      (port_id),
        .out_port     (out_port),
        .in_port      (in_port),
        .wr_fields    (wr_fields),
        .commit_pulse (commit_pulse),
        .field_en     (field_en),
        .rd_fields    (rd_fields),
        .xfer_req     (xfer_req),
        .xfer_ack     (xfer_ack)
    );

    // ---------------- scoreboard ----------------
    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [NF*DW-1:0] got,
                         input logic [NF*DW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    // All tasks start and end #1 after a rising edge.
    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic io_write(input logic [7:0] addr, input logic [7:0] data);
        port_id      = addr;
        out_port     = data;
        write_strobe = 1'b1;
        tick(1);
        write_strobe = 1'b0;
    endtask

    task automatic io_read(input logic [7:0] addr, input logic strobe,
                           output logic [7:0] data);
        port_id     = addr;
        read_strobe = strobe;
        tick(1);
        read_strobe = 1'b0;
        data        = in_port;
    endtask

    task automatic pulse_ack();
        xfer_ack = 1'b1;
        tick(1);
        xfer_ack = 1'b0;
    endtask

    logic [7:0] rd;

    initial begin
        reset = 1'b1; write_strobe = 1'b0; read_strobe = 1'b0;
        port_id = 8'h00; out_port = 8'h00; rd_fields = '0; xfer_ack = 1'b0;
        tick(2);
        reset = 1'b0;
        tick(5);

        // Reset state
        check("rst_in_port",   72'(in_port), 72'h0);
        check("rst_wr_fields", wr_fields, 72'h0);
        check("rst_commit",    72'(commit_pulse), 72'h0);
        check("rst_xfer_req",  72'(xfer_req), 72'h0);
        check("rst_field_en",  72'(field_en), 72'h001);
        io_read(8'h0C, 1'b0, rd);
        check("rst_status", 72'(rd), 72'h00);

        // Shadow writes do not reach wr_fields until COMMIT
        io_write(8'h02, 8'h24);
        io_write(8'h03, 8'h12);
        check("shadow_no_effect", wr_fields, 72'h0);
        io_write(8'h0B, 8'h01);
        check("commit_fields", wr_fields, 72'h1224);
        check("commit_pulse_hi", 72'(commit_pulse), 72'h1);
        tick(1);
        check("commit_pulse_lo", 72'(commit_pulse), 72'h0);
        // Last field boundary
        io_write(8'h0A, 8'hA5);
        check("shadow8_no_effect", wr_fields, 72'h1224);
        io_write(8'h0B, 8'h01);
        check("commit_field8", wr_fields, {8'hA5, 48'h0, 16'h1224});
        // Unknown command leaves everything alone
        io_write(8'h0B, 8'h7F);
        check("bad_cmd_commit", 72'(commit_pulse), 72'h0);
        check("bad_cmd_req", 72'(xfer_req), 72'h0);

        // Transfer handshake and sticky status
        io_write(8'h0B, 8'h02);
        check("start_req", 72'(xfer_req), 72'h1);
        io_read(8'h0C, 1'b0, rd);
        check("status_busy", 72'(rd), 72'h01);
        io_write(8'h0B, 8'h02);
        io_read(8'h0C, 1'b0, rd);
        check("status_err", 72'(rd), 72'h05);
        tick(4);
        check("req_held", 72'(xfer_req), 72'h1);
        pulse_ack();
        check("ack_req_low", 72'(xfer_req), 72'h0);
        io_read(8'h0C, 1'b0, rd);
        check("status_done", 72'(rd), 72'h06);
        io_read(8'h0C, 1'b1, rd);
        check("status_clr_read", 72'(rd), 72'h06);
        io_read(8'h0C, 1'b0, rd);
        check("status_cleared", 72'(rd), 72'h00);

        // Field select decode
        io_write(8'h01, 8'h08);
        check("field_en_8", 72'(field_en), 72'h100);
        io_write(8'h01, 8'h09);
        check("field_en_oor", 72'(field_en), 72'h000);
        io_read(8'h01, 1'b1, rd);
        check("sel_read", 72'(rd), 72'h09);

        // Snapshot coherence
        rd_fields = '0;
        rd_fields[31:24] = 8'h59;
        rd_fields[7:0]   = 8'h33;
        io_write(8'h0B, 8'h03);
        rd_fields = '0;
        io_read(8'h10, 1'b1, rd);
        check("snap_field3", 72'(rd), 72'h59);
        io_read(8'h0D, 1'b1, rd);
        check("snap_field0", 72'(rd), 72'h33);
        io_read(8'h20, 1'b1, rd);
        check("unmapped_read", 72'(rd), 72'h00);

        // Reset while busy; a later ack is ignored
        io_write(8'h0B, 8'h02);
        check("start2_req", 72'(xfer_req), 72'h1);
        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        check("reset_busy_req", 72'(xfer_req), 72'h0);
        check("reset_field_en", 72'(field_en), 72'h001);
        check("reset_wr_fields", wr_fields, 72'h0);
        pulse_ack();
        check("idle_ack_req", 72'(xfer_req), 72'h0);
        io_read(8'h0C, 1'b0, rd);
        check("idle_ack_status", 72'(rd), 72'h00);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
